// File: rtl/bmp_stream_writer_if.sv
// Pixel-in / byte-out bus of the BMP stream writer.
// master: upstream pixel source plus downstream byte sink (testbench side).
// slave : the writer itself.
interface bmp_stream_writer_if;
    logic       start;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       busy;
    logic       done;

    modport master (
        output start, pix_valid, pix_r, pix_g, pix_b, byte_ready,
        input  pix_ready, byte_valid, byte_data, byte_last, busy, done
    );

    modport slave (
        input  start, pix_valid, pix_r, pix_g, pix_b, byte_ready,
        output pix_ready, byte_valid, byte_data, byte_last, busy, done
    );
endinterface

// File: rtl/bmp_stream_writer.sv
// Streaming 24-bit BMP serializer: 54-byte header, then B,G,R bytes per pixel
// in arrival order with each row zero-padded to a multiple of 4 bytes.
// Optional macro BMP_WRITER_GRAYSCALE_EN: each pixel becomes Y=(R+2G+B)>>2 on
// all three channel bytes; header stays 24 bpp.
module bmp_stream_writer #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic              clk,
    input  logic              rst,
    bmp_stream_writer_if.slave bus
);
    localparam int ROWB  = ((WIDTH * 3 + 3) / 4) * 4;
    localparam int PADN  = ROWB - WIDTH * 3;
    localparam int IMGSZ = ROWB * HEIGHT;
    localparam int FSZ   = IMGSZ + 54;
    localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [1:0]    PAD_LAST = 2'(PADN - 1);

    // Header as a 54-byte little-endian ROM, byte 0 in bits [7:0].
    localparam logic [431:0] HDR = {
        128'd0,            // [38..53] resolution, palette fields
        32'(IMGSZ),        // [34..37] image size
        32'd0,             // [30..33] no compression
        16'd24,            // [28..29] bits per pixel
        16'd1,             // [26..27] planes
        32'(HEIGHT),       // [22..25]
        32'(WIDTH),        // [18..21]
        32'd40,            // [14..17] info header size
        32'd54,            // [10..13] pixel data offset
        32'd0,             // [6..9]   reserved
        32'(FSZ),          // [2..5]   file size
        8'h4D, 8'h42       // "BM"
    };

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_PAD, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [5:0]    hdr_q,   hdr_d;
    logic [CW-1:0] col_q,   col_d;
    logic [RW-1:0] row_q,   row_d;
    logic [1:0]    pad_q,   pad_d;
    logic [1:0]    chan_q,  chan_d;
    logic [7:0]    g_q,     g_d;
    logic [7:0]    r_q,     r_d;
    logic [7:0]    bdata_q, bdata_d;
    logic          bvalid_q, bvalid_d;
    logic          blast_q,  blast_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic          pix_ready_c;

    logic       xfer, slot_free;
    logic [7:0] px_r, px_g, px_b;

    assign xfer      = bvalid_q && bus.byte_ready;
    // Output register can take a new byte when empty or emptying this cycle.
    assign slot_free = !bvalid_q || bus.byte_ready;

`ifdef BMP_WRITER_GRAYSCALE_EN
    logic [9:0] y_sum;
    assign y_sum = {2'b00, bus.pix_r} + {1'b0, bus.pix_g, 1'b0} + {2'b00, bus.pix_b};
    assign px_r  = y_sum[9:2];
    assign px_g  = y_sum[9:2];
    assign px_b  = y_sum[9:2];
`else
    assign px_r  = bus.pix_r;
    assign px_g  = bus.pix_g;
    assign px_b  = bus.pix_b;
`endif

    // Next-state, counter and output-register load logic.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        col_d       = col_q;
        row_d       = row_q;
        pad_d       = pad_q;
        chan_d      = chan_q;
        g_d         = g_q;
        r_d         = r_q;
        bdata_d     = bdata_q;
        bvalid_d    = bvalid_q;
        blast_d     = blast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_ready_c = 1'b0;

        if (xfer) begin
            bvalid_d = 1'b0;
            blast_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_HDR;
                    busy_d  = 1'b1;
                    hdr_d   = '0;
                end
            end
            S_HDR: begin
                if (slot_free) begin
                    bdata_d  = HDR[{hdr_q, 3'b000} +: 8];
                    bvalid_d = 1'b1;
                    if (hdr_q == 6'd53) begin
                        state_d = S_PIX;
                        col_d   = '0;
                        row_d   = '0;
                        chan_d  = 2'd0;
                    end else begin
                        hdr_d = hdr_q + 6'd1;
                    end
                end
            end
            S_PIX: begin
                case (chan_q)
                    2'd0: begin
                        pix_ready_c = slot_free;
                        if (bus.pix_valid && slot_free) begin
                            bdata_d  = px_b;
                            bvalid_d = 1'b1;
                            g_d      = px_g;
                            r_d      = px_r;
                            chan_d   = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (slot_free) begin
                            bdata_d  = g_q;
                            bvalid_d = 1'b1;
                            chan_d   = 2'd2;
                        end
                    end
                    default: begin
                        if (slot_free) begin
                            bdata_d  = r_q;
                            bvalid_d = 1'b1;
                            chan_d   = 2'd0;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                if (PADN > 0) begin
                                    state_d = S_PAD;
                                    pad_d   = 2'd0;
                                end else if (row_q == ROW_LAST) begin
                                    state_d = S_FIN;
                                    blast_d = 1'b1;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
            S_PAD: begin
                if (slot_free) begin
                    bdata_d  = 8'h00;
                    bvalid_d = 1'b1;
                    if (pad_q == PAD_LAST) begin
                        pad_d = 2'd0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_FIN;
                            blast_d = 1'b1;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = S_PIX;
                        end
                    end else begin
                        pad_d = pad_q + 2'd1;
                    end
                end
            end
            S_FIN: begin
                // Only the final byte can be pending here.
                if (xfer) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any file in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hdr_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pad_q    <= '0;
            chan_q   <= '0;
            g_q      <= '0;
            r_q      <= '0;
            bdata_q  <= '0;
            bvalid_q <= 1'b0;
            blast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pad_q    <= pad_d;
            chan_q   <= chan_d;
            g_q      <= g_d;
            r_q      <= r_d;
            bdata_q  <= bdata_d;
            bvalid_q <= bvalid_d;
            blast_q  <= blast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.pix_ready  = pix_ready_c;
    assign bus.byte_valid = bvalid_q;
    assign bus.byte_data  = bdata_q;
    assign bus.byte_last  = blast_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench: three writers (2x2, 3x2 with 3 pad bytes, default 768x512).
module tb_bmp_stream_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        start_r [3];
    logic        pv      [3];
    logic        bp      [3];
    int unsigned pofs    [3];

    wire [7:0]  bd_w [3];
    wire        bv_w [3], bl_w [3], pr_w [3], busy_w [3], done_w [3];
    wire [31:0] pidx_w [3], ncap_w [3], dcnt_w [3], lcyc_w [3], dcyc_w [3], stall_w [3], acc_w [3];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    byte unsigned expq[$];

    localparam logic [7:0] E_B0 =
`ifdef BMP_WRITER_GRAYSCALE_EN
        8'h3C;
`else
        8'h5A;
`endif
    localparam logic [7:0] E_G0 = 8'h3C;
    localparam logic [7:0] E_R0 =
`ifdef BMP_WRITER_GRAYSCALE_EN
        8'h3C;
`else
        8'h1E;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel n of a file: two fixed pixels, then a simple ramp.
    function automatic logic [23:0] pixv(int unsigned n);
        logic [7:0] r, g, b;
        if (n == 0) return {8'd30, 8'd60, 8'd90};
        if (n == 1) return 24'hFFFFFF;
        r = 8'(n * 7 + 1);
        g = 8'(n * 5 + 64);
        b = 8'(n * 3 + 128);
        return {r, g, b};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W = (k == 0) ? 2 : (k == 1) ? 3 : 768;
        localparam int H = (k == 2) ? 512 : 2;

        bmp_stream_writer_if bif ();
        bmp_stream_writer #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bif));

        logic         rdy = 1'b1;
        byte unsigned cap[$];
        bit           lastf[$];
        int unsigned  pidx = 0, ncap = 0, dcnt = 0, stall = 0, acc = 0;
        int           lcyc = -1, dcyc = -1;
        logic         hold_v = 1'b0;
        logic [7:0]   hold_d = 8'h00;

        assign bif.start      = start_r[k];
        assign bif.pix_valid  = pv[k];
        assign bif.byte_ready = rdy;
        assign {bif.pix_r, bif.pix_g, bif.pix_b} = pixv(pidx - pofs[k]);

        assign bd_w[k]    = bif.byte_data;
        assign bv_w[k]    = bif.byte_valid;
        assign bl_w[k]    = bif.byte_last;
        assign pr_w[k]    = bif.pix_ready;
        assign busy_w[k]  = bif.busy;
        assign done_w[k]  = bif.done;
        assign pidx_w[k]  = pidx;
        assign ncap_w[k]  = ncap;
        assign dcnt_w[k]  = dcnt;
        assign lcyc_w[k]  = lcyc;
        assign dcyc_w[k]  = dcyc;
        assign stall_w[k] = stall;
        assign acc_w[k]   = acc;

        always @(negedge clk) rdy <= bp[k] ? 1'($urandom_range(1)) : 1'b1;

        always @(posedge clk) begin
            if (bif.byte_valid && bif.byte_ready) begin
                cap.push_back(bif.byte_data);
                lastf.push_back(bif.byte_last);
                ncap <= ncap + 1;
                if (bif.byte_last) lcyc <= cyc;
            end
            if (!rst && hold_v && (!bif.byte_valid || bif.byte_data !== hold_d)) stall <= stall + 1;
            hold_v <= bif.byte_valid && !bif.byte_ready;
            hold_d <= bif.byte_data;
            if (bif.pix_valid && bif.pix_ready) begin
                pidx <= pidx + 1;
                if (bif.byte_valid && !bif.byte_ready) acc <= acc + 1;
            end
            if (bif.done) begin
                dcnt <= dcnt + 1;
                dcyc <= cyc;
            end
        end
    end

    function automatic logic [7:0] getb(int k, int i);
        case (k)
            0:       return g[0].cap[i];
            1:       return g[1].cap[i];
            default: return g[2].cap[i];
        endcase
    endfunction

    function automatic bit getl(int k, int i);
        case (k)
            0:       return g[0].lastf[i];
            1:       return g[1].lastf[i];
            default: return g[2].lastf[i];
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_le(int v, int nb);
        for (int i = 0; i < nb; i++) expq.push_back(8'((v >> (8 * i)) & 255));
    endtask

    // Expected byte stream for a w x h image fed with pixv(0..w*h-1).
    task automatic build_exp(int w, int h);
        int rowb, img, y;
        logic [23:0] p;
        expq.delete();
        rowb = ((w * 3 + 3) / 4) * 4;
        img  = rowb * h;
        push_le(32'h4D42, 2); push_le(img + 54, 4); push_le(0, 4); push_le(54, 4);
        push_le(40, 4); push_le(w, 4); push_le(h, 4); push_le(1, 2); push_le(24, 2);
        push_le(0, 4); push_le(img, 4);
        for (int i = 0; i < 16; i++) expq.push_back(8'h00);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                p = pixv(r * w + c);
`ifdef BMP_WRITER_GRAYSCALE_EN
                y = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
                repeat (3) expq.push_back(8'(y));
`else
                y = 0;
                expq.push_back(p[7:0]); expq.push_back(p[15:8]); expq.push_back(p[23:16]);
`endif
            end
            for (int i = w * 3; i < rowb; i++) expq.push_back(8'h00);
        end
    endtask

    task automatic cmp_stream(int k, int base, string tag);
        int n, bad, lc, lp;
        n = int'(ncap_w[k]) - base;
        chk({tag, "_len"}, n, expq.size());
        bad = 0;
        for (int i = 0; i < n && i < expq.size(); i++)
            if (getb(k, base + i) !== expq[i]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        lc = 0; lp = -1;
        for (int i = 0; i < n; i++)
            if (getl(k, base + i)) begin lc++; lp = i; end
        chk({tag, "_last_cnt"}, lc, 1);
        chk({tag, "_last_pos"}, lp, n - 1);
    endtask

    task automatic start_file(int k, output int base, output int d0);
        @(negedge clk);
        pofs[k]    = pidx_w[k];
        base       = ncap_w[k];
        d0         = dcnt_w[k];
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
    endtask

    task automatic pulse_start(int k);
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget, string tag);
        int n = 0;
        while (!done_w[k] && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_done_in_time"}, n < budget, 1);
    endtask

    task automatic wait_bytes(int k, int cnt, int budget, string tag);
        int n = 0;
        while (int'(ncap_w[k]) < cnt && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_bytes_in_time"}, n < budget, 1);
    endtask

    task automatic chk_zero_out(int k, string tag);
        chk({tag, "_pix_ready"}, pr_w[k], 0);
        chk({tag, "_byte_valid"}, bv_w[k], 0);
        chk({tag, "_byte_data"}, bd_w[k], 0);
        chk({tag, "_byte_last"}, bl_w[k], 0);
        chk({tag, "_busy"}, busy_w[k], 0);
        chk({tag, "_done"}, done_w[k], 0);
    endtask

    initial begin
        int b1, b2, b3, d0, bad;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0; pv[k] = 1'b0; bp[k] = 1'b0; pofs[k] = 0;
        end
        #2;
        chk_zero_out(0, "reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 2x2 file, ready always high, stray starts in HDR and PIX.
        pv[0] = 1'b1;
        build_exp(2, 2);
        start_file(0, b1, d0);
        chk("a_busy_after_start", busy_w[0], 1);
        chk("a_no_pix_in_hdr", pr_w[0], 0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_bytes(0, b1 + 56, 300, "a_pix");
        pulse_start(0);
        wait_done(0, 300, "a");
        chk("a_busy_at_done", busy_w[0], 0);
        @(negedge clk);
        chk("a_done_count", dcnt_w[0] - d0, 1);
        chk("a_done_after_last", dcyc_w[0], lcyc_w[0] + 1);
        chk("a_done_one_cycle", done_w[0], 0);
        chk("a_hdr_fsz", getb(0, b1 + 2), 8'h46);
        chk("a_hdr_w", getb(0, b1 + 18), 8'd2);
        chk("a_hdr_h", getb(0, b1 + 22), 8'd2);
        chk("a_hdr_img", getb(0, b1 + 34), 8'd16);
        chk("a_p0_b", getb(0, b1 + 54), E_B0);
        chk("a_p0_g", getb(0, b1 + 55), E_G0);
        chk("a_p0_r", getb(0, b1 + 56), E_R0);
        chk("a_p1_b", getb(0, b1 + 57), 8'hFF);
        chk("a_p1_r", getb(0, b1 + 59), 8'hFF);
        chk("a_pad0", getb(0, b1 + 60), 8'h00);
        chk("a_pad1", getb(0, b1 + 61), 8'h00);
        cmp_stream(0, b1, "a");
        repeat (5) @(negedge clk);
        chk("a_pixels_used", pidx_w[0] - pofs[0], 4);

        // Second start from IDLE reproduces the same file.
        start_file(0, b2, d0);
        wait_done(0, 300, "b");
        @(negedge clk);
        cmp_stream(0, b2, "b");
        bad = 0;
        for (int i = 0; i < 70; i++) if (getb(0, b1 + i) !== getb(0, b2 + i)) bad++;
        chk("b_same_as_a", bad, 0);

        // Reset in the middle of the pixel section.
        start_file(0, b3, d0);
        wait_bytes(0, b3 + 60, 300, "c");
        rst = 1'b1;
        #1;
        chk_zero_out(0, "c_midreset");
        @(negedge clk);
        rst = 1'b0;
        start_file(0, b3, d0);
        wait_done(0, 300, "d");
        @(negedge clk);
        cmp_stream(0, b3, "d");

        // 3x2 (3 pad bytes per row): ready=1 run, then random backpressure.
        pv[1] = 1'b1;
        build_exp(3, 2);
        start_file(1, b1, d0);
        wait_done(1, 500, "e");
        @(negedge clk);
        cmp_stream(1, b1, "e");
        chk("e_hdr_fsz", getb(1, b1 + 2), 8'h4E);
        bp[1] = 1'b1;
        start_file(1, b2, d0);
        wait_done(1, 3000, "f");
        @(negedge clk);
        bp[1] = 1'b0;
        cmp_stream(1, b2, "f");
        bad = 0;
        for (int i = 0; i < 78; i++) if (getb(1, b1 + i) !== getb(1, b2 + i)) bad++;
        chk("f_same_as_e", bad, 0);
        chk("f_stall_stable", stall_w[1], 0);
        chk("f_no_accept_when_full", acc_w[1], 0);

        // Default 768x512: header only, then abort with reset.
        pv[2] = 1'b1;
        start_file(2, b1, d0);
        wait_bytes(2, b1 + 54, 300, "g");
        chk("g_fsz0", getb(2, b1 + 2), 8'h36);
        chk("g_fsz1", getb(2, b1 + 3), 8'h00);
        chk("g_fsz2", getb(2, b1 + 4), 8'h12);
        chk("g_fsz3", getb(2, b1 + 5), 8'h00);
        chk("g_img0", getb(2, b1 + 34), 8'h00);
        chk("g_img1", getb(2, b1 + 35), 8'h00);
        chk("g_img2", getb(2, b1 + 36), 8'h12);
        chk("g_img3", getb(2, b1 + 37), 8'h00);
        chk("g_w0", getb(2, b1 + 18), 8'h00);
        chk("g_w1", getb(2, b1 + 19), 8'h03);
        chk("g_h1", getb(2, b1 + 23), 8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("g_busy_after_abort", busy_w[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
